// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared state encoding and default widths for the counter tile pair
package checker_pkg;

  // Sequence-checker state encoding
  localparam logic ST_HUNT   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // Defaults shared with the free-running counter tile
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ERR_W = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clear-priority saturating up-counter
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  // Clear beats increment; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/counter_seq_checker.sv
// rtl/counter_seq_checker.sv - checks an observed count bus advances by +1 every clock
module counter_seq_checker
  import checker_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 3,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] exp_o
);

  localparam int GW = (LOCK_N   < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam int BW = (UNLOCK_N < 2) ? 1 : $clog2(UNLOCK_N + 1);

  logic             state;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s0;
  logic             seen;
  logic             primed;
  logic [GW-1:0]    good_run;
  logic [BW-1:0]    bad_run;
  logic             step_ok;
  logic             err_inc;

  // Wrap from all-ones to zero is a legal step because the sum is truncated to WIDTH
  assign step_ok  = (s1 == s0 + WIDTH'(1));
  // A break only counts once both sample stages hold real data and we are locked
  assign err_inc  = primed && (state == ST_LOCKED) && !step_ok;
  assign locked_o = (state == ST_LOCKED);

  // Sample pipeline, priming, lock/unlock state machine and registered err/exp outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_HUNT;
      s1       <= '0;
      s0       <= '0;
      seen     <= 1'b0;
      primed   <= 1'b0;
      good_run <= '0;
      bad_run  <= '0;
      err_o    <= 1'b0;
      exp_o    <= '0;
    end else begin
      s1     <= data_i;
      s0     <= s1;
      exp_o  <= data_i + WIDTH'(1);
      seen   <= 1'b1;
      primed <= seen;
      err_o  <= err_inc;
      if (primed) begin
        if (state == ST_HUNT) begin
          if (!step_ok) begin
            good_run <= '0;
          end else if (good_run == GW'(LOCK_N - 1)) begin
            state    <= ST_LOCKED;
            good_run <= '0;
            bad_run  <= '0;
          end else begin
            good_run <= good_run + GW'(1);
          end
        end else begin
          if (step_ok) begin
            bad_run <= '0;
          end else if (bad_run == BW'(UNLOCK_N - 1)) begin
            state    <= ST_HUNT;
            good_run <= '0;
            bad_run  <= '0;
          end else begin
            bad_run <= bad_run + BW'(1);
          end
        end
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (err_inc),
    .clr_i (clr_i),
    .cnt_o (err_cnt_o)
  );

endmodule

// File: tb/tb_counter_seq_checker.sv
// tb/tb_counter_seq_checker.sv - self-checking bench for counter_seq_checker
module tb_counter_seq_checker;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] data_i;
  logic       clr_i;
  logic       locked_o;
  logic       err_o;
  logic [7:0] err_cnt_o;
  logic [7:0] exp_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       locked;
    logic       err;
    logic [7:0] cnt;
    logic [7:0] expv;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       locked;
    logic       err;
    logic [7:0] expv;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  // reference model state
  int m_nsamp, m_h0, m_h1, m_good, m_bad, m_cnt;
  logic m_locked;

  always #5 clk = ~clk;

  counter_seq_checker dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .clr_i     (clr_i),
    .locked_o  (locked_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o),
    .exp_o     (exp_o)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_nsamp = 0; m_h0 = 0; m_h1 = 0; m_good = 0; m_bad = 0; m_cnt = 0;
    m_locked = 1'b0;
  endtask

  // what the outputs must look like after the edge that samples d
  task automatic model_edge(input int d, input logic c, output exp_t e);
    logic errn;
    logic ok;
    errn = 1'b0;
    ok = (m_h1 == ((m_h0 + 1) % 256));
    if (m_nsamp >= 2) begin
      if (m_locked) begin
        if (!ok) begin
          errn = 1'b1;
          m_bad++;
          if (m_bad == 3) begin
            m_locked = 1'b0; m_good = 0; m_bad = 0;
          end
        end else begin
          m_bad = 0;
        end
      end else begin
        if (ok) begin
          m_good++;
          if (m_good == 4) begin
            m_locked = 1'b1; m_good = 0; m_bad = 0;
          end
        end else begin
          m_good = 0;
        end
      end
    end
    if (c) m_cnt = 0;
    else if (errn && m_cnt < 255) m_cnt++;
    m_h0 = m_h1;
    m_h1 = d;
    if (m_nsamp < 2) m_nsamp++;
    e.locked = m_locked;
    e.err    = errn;
    e.cnt    = 8'(m_cnt);
    e.expv   = 8'((d + 1) % 256);
  endtask

  task automatic step(input int d, input logic c);
    exp_t e;
    data_i = 8'(d);
    clr_i  = c;
    model_edge(d, c, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("locked", int'(locked_o), int'(e.locked));
    chk("err", int'(err_o), int'(e.err));
    chk("err_cnt", int'(err_cnt_o), int'(e.cnt));
    chk("exp", int'(exp_o), int'(e.expv));
  endtask

  initial begin
    int v;
    int pulses;
    for (int i = 0; i < 8; i++) begin
      tbl[i].data   = 8'(i);
      tbl[i].locked = (i >= 5);
      tbl[i].err    = 1'b0;
      tbl[i].expv   = 8'(i + 1);
    end

    rst_i = 1'b0; data_i = 8'h00; clr_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_cnt", int'(err_cnt_o), 0);
    chk("rst_exp", int'(exp_o), 0);
    @(negedge clk);
    rst_i = 1'b1;

    // 1: lock acquisition from a clean count
    for (int i = 0; i < 8; i++) begin
      step(int'(tbl[i].data), 1'b0);
      chk("t1_locked", int'(locked_o), int'(tbl[i].locked));
      chk("t1_err", int'(err_o), int'(tbl[i].err));
      chk("t1_exp", int'(exp_o), int'(tbl[i].expv));
    end

    // 2: wrap through 0xFF -> 0x00
    pulses = 0;
    for (v = 8; v <= 16'h101; v++) begin
      step(v % 256, 1'b0);
      pulses += int'(err_o);
    end
    chk("t2_pulses", pulses, 0);
    chk("t2_locked", int'(locked_o), 1);

    // 3: single glitch -> two bad steps, lock kept
    for (v = 2; v <= 16'h11; v++) step(v, 1'b0);
    pulses = 0;
    step(8'h55, 1'b0); pulses += int'(err_o);
    step(8'h13, 1'b0); pulses += int'(err_o);
    chk("t3_first_err", int'(err_o), 1);
    step(8'h14, 1'b0); pulses += int'(err_o);
    chk("t3_second_err", int'(err_o), 1);
    step(8'h15, 1'b0); pulses += int'(err_o);
    chk("t3_pulses", pulses, 2);
    chk("t3_cnt", int'(err_cnt_o), 2);
    chk("t3_locked", int'(locked_o), 1);

    // 4: stuck bus -> exactly three pulses then HUNT
    for (v = 16'h16; v <= 16'h40; v++) step(v, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(8'h40, 1'b0);
      pulses += int'(err_o);
    end
    chk("t4_pulses", pulses, 3);
    chk("t4_cnt", int'(err_cnt_o), 5);
    chk("t4_locked", int'(locked_o), 0);

    // 5: relock, then 300 isolated jumps saturate the counter
    v = 16'h40;
    for (int i = 0; i < 8; i++) begin
      v++;
      step(v % 256, 1'b0);
    end
    chk("t5_relock", int'(locked_o), 1);
    for (int i = 0; i < 300; i++) begin
      v += 3; step(v % 256, 1'b0);
      v += 1; step(v % 256, 1'b0);
    end
    chk("t5_sat", int'(err_cnt_o), 255);
    chk("t5_locked", int'(locked_o), 1);
    v += 3; step(v % 256, 1'b0);
    v += 1; step(v % 256, 1'b1);
    chk("t5_clr_err", int'(err_o), 1);
    chk("t5_clr_cnt", int'(err_cnt_o), 0);
    v += 1; step(v % 256, 1'b0);
    chk("t5_after_clr", int'(err_cnt_o), 0);

    // 6: async reset between edges while locked, then relock from scratch
    v += 3; step(v % 256, 1'b0);
    v += 1; step(v % 256, 1'b0);
    #3;
    rst_i = 1'b0;
    #1;
    chk("t6_locked", int'(locked_o), 0);
    chk("t6_err", int'(err_o), 0);
    chk("t6_cnt", int'(err_cnt_o), 0);
    chk("t6_exp", int'(exp_o), 0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(int'(tbl[i].data) + 16'h20, 1'b0);
      chk("t6_relock", int'(locked_o), int'(tbl[i].locked));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
